wire_alu_bank: RTL and testbench
================================

Name: wire_alu_bank

Overview:
- Parametrised, multi-channel successor to the single fixed-width wire-in adder used in our FrontPanel samples.
- Each channel samples two operands from wire-ins on a trigger-in start pulse and executes ADD, SUB, ACCumulate or a shift-add MULtiply.
- Each channel registers its result for wire-out readback, with busy/done status and a sticky overflow flag.
- Sits between okWireIn/okTriggerIn endpoints and okWireOut endpoints, entirely in the ti_clk domain.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- NCH, 2, number of independent channels.
- SAT, 0, 1 = clamp result on overflow; 0 = wrap modulo 2^WIDTH.

Ports:
- ti_clk  in  1  host interface clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  NCH  per-channel one-cycle start strobe (trigger-in).
- mode  in  2*NCH  per-channel opcode, channel c at [2c+1:2c].
- op_a  in  NCH*WIDTH  operand A, channel c at [c*WIDTH +: WIDTH].
- op_b  in  NCH*WIDTH  operand B, same packing.
- clr_ovf  in  NCH  per-channel sticky-overflow clear strobe.
- result  out  NCH*WIDTH  registered result, same packing.
- busy  out  NCH  channel executing a multi-cycle op.
- done  out  NCH  one-cycle pulse when the result updates.
- ovf  out  NCH  sticky overflow flag.

Behaviour:
- Reset: result=0, busy=0, done=0, ovf=0, multiplier state cleared.
- Channels are fully independent; they share no state.
- Opcodes: 0 ADD, 1 SUB, 2 ACC, 3 MUL. All arithmetic is unsigned.
- Start is accepted only when busy=0 for that channel.
  - A start while busy is ignored: no effect, no queueing.
- mode, op_a and op_b are sampled in the accept cycle. Later input changes do not affect the op in flight.
- ADD: result=A+B. Overflow = carry out of bit WIDTH-1.
- SUB: result=A-B. Overflow = borrow (A<B).
- ACC: result=result+A; B is ignored. Overflow = carry.
- Single-cycle ops (ADD/SUB/ACC), start accepted in cycle t:
  - result and done=1 visible in cycle t+1.
  - busy stays 0.
  - Back-to-back starts on consecutive cycles are legal; each produces its own done.
- MUL: shift-add over WIDTH iterations with a 2*WIDTH-bit partial product.
  - busy=1 in cycles t+1 … t+WIDTH.
  - In cycle t+WIDTH+1: result = low WIDTH product bits, done=1, busy=0.
  - Overflow = any nonzero high product bit.
  - A start in cycle t+WIDTH+1 is accepted.
- SAT=1 on overflow:
  - ADD/ACC/MUL clamp to all-ones.
  - SUB clamps to 0.
  - ovf is still set.
- ovf is set on any overflowing op and is cleared only by clr_ovf or reset.
  - If clr_ovf and a new overflow occur in the same cycle, set wins (ovf=1).
- result holds its value between ops. ACC uses the currently held result.
- done is high for exactly one cycle per completed op and is never asserted for an ignored start.
- reset asserted mid-MUL: the op aborts, the reset values apply next cycle, and no done is issued.

Decomposition:
- Shared package/include wire_alu_pkg:
  - opcode constants OP_ADD=2'd0, OP_SUB=2'd1, OP_ACC=2'd2, OP_MUL=2'd3.
  - mode field width constant.
- One sub-module, wire_alu_chan: a single-channel datapath plus a 2-state FSM.
  - States: IDLE, MUL_RUN. The iteration counter is $clog2(WIDTH)+1 bits.
- The top level instantiates NCH copies in a generate loop and handles bus packing only.

Test Plan:
- (WIDTH=32, NCH=2, SAT=0) ch0 ADD A=0xFFFFFFFF, B=2, start at t → cycle t+1: result0=0x00000001, done0=1, ovf0=1; clr_ovf0 pulse → ovf0=0.
- ch1 SUB A=5, B=7 → result1=0xFFFFFFFE, ovf1=1. Repeat with SAT=1 → result1=0, ovf1=1.
- ch0 ADD 10+0, then ACC A=5 three times on consecutive cycles → results 15, 20, 25; three done pulses; ovf0=0.
- ch0 MUL A=0x10000, B=0x10001 → busy0 high 32 cycles, result0=0x00010000, done0 at t+33, ovf0=1. Simultaneously ch1 ADD 3+4 → result1=7 at t+1, unaffected by ch0.
- ch0 MUL 6×7 with an extra start (ADD 1+1) at t+10 → extra start ignored; result0=42 at t+33; exactly one done pulse.
- ch0 MUL 6×7 with reset asserted at t+15 → busy0=0, result0=0, done0=0 from t+16. A fresh ADD 1+1 after reset deasserts → result0=2 after 1 cycle.

Source files
------------

// File: rtl/wire_alu_pkg.sv
// wire_alu_pkg: opcodes, mode field width and channel FSM states shared by the ALU bank.
package wire_alu_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] OP_ADD = 2'd0;
    localparam logic [MODE_W-1:0] OP_SUB = 2'd1;
    localparam logic [MODE_W-1:0] OP_ACC = 2'd2;
    localparam logic [MODE_W-1:0] OP_MUL = 2'd3;

    typedef enum logic {IDLE, MUL_RUN} chan_state_t;

endpackage

// File: rtl/wire_alu_chan.sv
// wire_alu_chan: one ALU channel with single-cycle ADD/SUB/ACC and a shift-add multiplier.
module wire_alu_chan
    import wire_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit SAT   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic              clr_ovf_i,
    output logic [WIDTH-1:0]  result_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    chan_state_t       state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] mcand_q, prod_q, prod_d;
    logic [WIDTH-1:0]  mplier_q, result_q, fast_res, mul_res;
    logic [WIDTH:0]    add_w, sub_w, acc_w, fast_w;
    logic              done_q, ovf_q, fast_ovf, mul_ovf, accept, last, ovf_set;

    // Operation results, overflow detection and saturation; bit WIDTH of each sum is carry/borrow.
    always_comb begin
        add_w    = {1'b0, a_i} + {1'b0, b_i};
        sub_w    = {1'b0, a_i} - {1'b0, b_i};
        acc_w    = {1'b0, result_q} + {1'b0, a_i};
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        fast_w   = (mode_i == OP_ADD) ? add_w : (mode_i == OP_SUB) ? sub_w : acc_w;
        fast_ovf = fast_w[WIDTH];
        fast_res = (SAT && fast_ovf) ? ((mode_i == OP_SUB) ? '0 : '1) : fast_w[WIDTH-1:0];
        mul_ovf  = |prod_d[2*WIDTH-1:WIDTH];
        mul_res  = (SAT && mul_ovf) ? '1 : prod_d[WIDTH-1:0];
        accept   = (state_q == IDLE) && start_i;
        last     = (state_q == MUL_RUN) && (cnt_q == LAST);
        ovf_set  = (accept && mode_i != OP_MUL && fast_ovf) || (last && mul_ovf);
    end

    // Channel FSM: single-cycle ops complete on accept, MUL iterates WIDTH cycles in MUL_RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= (accept && mode_i != OP_MUL) || last;
            ovf_q  <= ovf_set | (ovf_q & ~clr_ovf_i);
            if (accept && mode_i == OP_MUL) begin
                state_q  <= MUL_RUN;
                cnt_q    <= '0;
                prod_q   <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, a_i};
                mplier_q <= b_i;
            end else if (accept) begin
                result_q <= fast_res;
            end else if (state_q == MUL_RUN) begin
                prod_q   <= prod_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
                if (last) begin
                    result_q <= mul_res;
                    state_q  <= IDLE;
                end
            end
        end
    end

    assign result_o = result_q;
    assign busy_o   = (state_q == MUL_RUN);
    assign done_o   = done_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/wire_alu_bank.sv
// wire_alu_bank: NCH independent ALU channels behind packed wire-in/trigger-in/wire-out buses.
module wire_alu_bank
    import wire_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int SAT   = 0
) (
    input  logic                  ti_clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        start,
    input  logic [MODE_W*NCH-1:0] mode,
    input  logic [NCH*WIDTH-1:0]  op_a,
    input  logic [NCH*WIDTH-1:0]  op_b,
    input  logic [NCH-1:0]        clr_ovf,
    output logic [NCH*WIDTH-1:0]  result,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        done,
    output logic [NCH-1:0]        ovf
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        wire_alu_chan #(
            .WIDTH(WIDTH),
            .SAT  (SAT != 0)
        ) u_chan (
            .clk_i    (ti_clk),
            .rst_i    (reset),
            .start_i  (start[c]),
            .mode_i   (mode[MODE_W*c +: MODE_W]),
            .a_i      (op_a[c*WIDTH +: WIDTH]),
            .b_i      (op_b[c*WIDTH +: WIDTH]),
            .clr_ovf_i(clr_ovf[c]),
            .result_o (result[c*WIDTH +: WIDTH]),
            .busy_o   (busy[c]),
            .done_o   (done[c]),
            .ovf_o    (ovf[c])
        );
    end

endmodule

// File: tb/tb_wire_alu_bank.sv
// tb_wire_alu_bank: scoreboard bench driving a wrapping and a saturating bank with identical stimulus.
module tb_wire_alu_bank;

    localparam int W = 32;
    localparam int N = 2;
    localparam logic [63:0] MAXV = 64'hFFFF_FFFF;

    logic           ti_clk = 1'b0;
    logic           reset;
    logic [N-1:0]   start, clr_ovf;
    logic [2*N-1:0] mode;
    logic [N*W-1:0] op_a, op_b;
    logic [N*W-1:0] result0, result1;
    logic [N-1:0]   busy0, busy1, done0, done1, ovf0, ovf1;

    wire_alu_bank #(.WIDTH(W), .NCH(N), .SAT(0)) u_wrap (
        .ti_clk(ti_clk), .reset(reset), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
        .clr_ovf(clr_ovf), .result(result0), .busy(busy0), .done(done0), .ovf(ovf0)
    );

    wire_alu_bank #(.WIDTH(W), .NCH(N), .SAT(1)) u_sat (
        .ti_clk(ti_clk), .reset(reset), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
        .clr_ovf(clr_ovf), .result(result1), .busy(busy1), .done(done1), .ovf(ovf1)
    );

    always #5 ti_clk = ~ti_clk;

    // Lane l = dut*2 + channel; dut 0 wraps, dut 1 saturates.
    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t         sb[4][$];
    logic [W-1:0] m_res[4];
    logic         m_ovf[4];
    int           busy_until[2];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    always @(posedge ti_clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] res_of(int l);
        return (l < 2) ? result0[l*W +: W] : result1[(l-2)*W +: W];
    endfunction
    function automatic logic busy_of(int l);
        return (l < 2) ? busy0[l] : busy1[l-2];
    endfunction
    function automatic logic done_of(int l);
        return (l < 2) ? done0[l] : done1[l-2];
    endfunction
    function automatic logic ovf_of(int l);
        return (l < 2) ? ovf0[l] : ovf1[l-2];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive an op for channel c (at a negedge) and model it at the abstraction of the op's arithmetic.
    task automatic op(int c, logic [1:0] md, logic [W-1:0] a, logic [W-1:0] b);
        int           e;
        int           l;
        logic [63:0]  full;
        logic         ov;
        logic [W-1:0] r;
        e = cyc + 1;
        start[c]        = 1'b1;
        mode[2*c +: 2]  = md;
        op_a[c*W +: W]  = a;
        op_b[c*W +: W]  = b;
        if (e <= busy_until[c]) return;
        if (md == 2'd3) busy_until[c] = e + W;
        for (int s = 0; s < 2; s++) begin
            l = s*2 + c;
            case (md)
                2'd0: begin full = 64'(a) + 64'(b); ov = full > MAXV; end
                2'd1: begin full = 64'(a) - 64'(b); ov = a < b; end
                2'd2: begin full = 64'(m_res[l]) + 64'(a); ov = full > MAXV; end
                default: begin full = 64'(a) * 64'(b); ov = full > MAXV; end
            endcase
            r = full[W-1:0];
            if (ov && s == 1) r = (md == 2'd1) ? '0 : '1;
            m_res[l] = r;
            m_ovf[l] = m_ovf[l] | ov;
            sb[l].push_back(exp_t'{r, m_ovf[l]});
        end
    endtask

    task automatic clear(int c);
        clr_ovf[c] = 1'b1;
        m_ovf[c]   = 1'b0;
        m_ovf[c+2] = 1'b0;
    endtask

    task automatic tick();
        @(posedge ti_clk);
        @(negedge ti_clk);
        start   = '0;
        clr_ovf = '0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0: return '1;
            1: return W'($urandom_range(0, 15));
            2: return W'($urandom_range(0, 65535));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse pops the oldest expected response of its lane.
    always @(negedge ti_clk) begin
        if (reset === 1'b0) begin
            for (int l = 0; l < 4; l++) begin
                if (done_of(l)) begin
                    if (sb[l].size() == 0) begin
                        chk($sformatf("lane%0d_unexpected_done", l), 1, 0);
                    end else begin
                        exp_t x;
                        x = sb[l].pop_front();
                        chk($sformatf("lane%0d_result", l), res_of(l), x.res);
                        chk($sformatf("lane%0d_ovf", l), ovf_of(l), x.ovf);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; start = '0; clr_ovf = '0; mode = '0; op_a = '0; op_b = '0;
        for (int l = 0; l < 4; l++) begin m_res[l] = '0; m_ovf[l] = 1'b0; end
        busy_until[0] = 0; busy_until[1] = 0;
        repeat (3) @(negedge ti_clk);
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("reset_result%0d", l), res_of(l), 0);
            chk($sformatf("reset_busy%0d", l), busy_of(l), 0);
            chk($sformatf("reset_done%0d", l), done_of(l), 0);
            chk($sformatf("reset_ovf%0d", l), ovf_of(l), 0);
        end
        reset = 1'b0;

        op(0, 2'd0, 32'hFFFF_FFFF, 32'd2); tick();
        chk("add_carry_ovf", ovf_of(0), 1);
        clear(0); tick();
        chk("clr_ovf_wrap", ovf_of(0), 0);
        chk("clr_ovf_sat", ovf_of(2), 0);

        op(1, 2'd1, 32'd5, 32'd7); tick();
        clear(1); tick();

        clear(1); op(1, 2'd0, 32'hFFFF_FFFF, 32'd1); tick();
        chk("clr_and_set_same_cycle", ovf_of(1), 1);
        clear(1); tick();

        op(0, 2'd0, 32'd10, 32'd0); tick();
        repeat (3) begin op(0, 2'd2, 32'd5, 32'd0); tick(); end
        chk("acc_no_ovf", ovf_of(0), 0);
        chk("acc_final", res_of(0), 25);

        op(0, 2'd3, 32'h0001_0000, 32'h0001_0001);
        op(1, 2'd0, 32'd3, 32'd4);
        tick();
        n = 0;
        while (busy_of(0) && n < 100) begin n++; tick(); end
        chk("mul_busy_cycles", n, 32);
        clear(0); tick();

        op(0, 2'd3, 32'd6, 32'd7); tick();
        repeat (8) tick();
        op(0, 2'd0, 32'd1, 32'd1);
        n = 0;
        repeat (40) begin tick(); n += int'(done_of(0)); end
        chk("mul_single_done", n, 1);
        chk("mul_6x7", res_of(0), 42);

        op(0, 2'd3, 32'd6, 32'd7); tick();
        repeat (13) tick();
        reset = 1'b1;
        for (int l = 0; l < 4; l++) begin sb[l].delete(); m_res[l] = '0; m_ovf[l] = 1'b0; end
        busy_until[0] = 0; busy_until[1] = 0;
        tick();
        chk("rst_mid_mul_busy", busy_of(0), 0);
        chk("rst_mid_mul_result", res_of(0), 0);
        chk("rst_mid_mul_done", done_of(0), 0);
        chk("rst_mid_mul_busy_sat", busy_of(2), 0);
        reset = 1'b0;
        op(0, 2'd0, 32'd1, 32'd1); tick();
        chk("add_after_reset", res_of(0), 2);

        repeat (300) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 3) == 0) op(c, 2'($urandom_range(0, 3)), pick(), pick());
            tick();
        end
        repeat (W + 5) tick();
        for (int l = 0; l < 4; l++) chk($sformatf("lane%0d_drained", l), sb[l].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
